// File: rtl/ether_pkg.sv
// Shared definitions for the RMII receive path: FSM state encoding and the
// line dibits that delimit a frame's preamble.
package ether_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREAMBLE = 2'd1,
    DATA     = 2'd2,
    DISCARD  = 2'd3
  } ether_state_t;

  localparam logic [1:0] PREAMBLE_DIBIT = 2'b01;
  localparam logic [1:0] SFD_DIBIT      = 2'b11;

endpackage

// File: rtl/ether_rx.sv
// RMII receive framer: strips preamble/SFD and streams payload dibits (FCS included).
// Optional build macro ETHER_RX_ERR_EN adds err_out, pulsed on every entry to DISCARD.
module ether_rx
  import ether_pkg::*;
#(
  parameter int MIN_PREAMBLE = 8
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       crsdv_in,
  input  logic [1:0] rxd_in,
  output logic       axiov,
  output logic [1:0] axiod,
  output logic       sof_out,
  output logic       eof_out
`ifdef ETHER_RX_ERR_EN
  ,
  output logic       err_out
`endif
);

  localparam logic [4:0] MIN_CNT = 5'(MIN_PREAMBLE);

  ether_state_t state;
  logic [4:0]   count;
  // Cleared by reset; a carrier already up on the first cycle out of reset
  // is a frame joined mid-stream and must be thrown away.
  logic         armed;
  // Set on SFD, cleared by the first payload dibit; also tells a zero-length
  // frame apart so it produces no eof_out.
  logic         first;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state   <= IDLE;
      count   <= '0;
      armed   <= 1'b0;
      first   <= 1'b0;
      axiov   <= 1'b0;
      axiod   <= 2'b00;
      sof_out <= 1'b0;
      eof_out <= 1'b0;
`ifdef ETHER_RX_ERR_EN
      err_out <= 1'b0;
`endif
    end else begin
      armed   <= 1'b1;
      axiov   <= 1'b0;
      axiod   <= 2'b00;
      sof_out <= 1'b0;
      eof_out <= 1'b0;
`ifdef ETHER_RX_ERR_EN
      err_out <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (crsdv_in) begin
            if (armed && rxd_in == PREAMBLE_DIBIT) begin
              state <= PREAMBLE;
              count <= 5'd1;
            end else begin
              state <= DISCARD;
`ifdef ETHER_RX_ERR_EN
              err_out <= 1'b1;
`endif
            end
          end
        end
        PREAMBLE: begin
          if (!crsdv_in) begin
            state <= IDLE;
          end else if (rxd_in == PREAMBLE_DIBIT) begin
            if (count != 5'd31) count <= count + 5'd1;
          end else if (rxd_in == SFD_DIBIT && count >= MIN_CNT) begin
            state <= DATA;
            first <= 1'b1;
          end else begin
            state <= DISCARD;
`ifdef ETHER_RX_ERR_EN
            err_out <= 1'b1;
`endif
          end
        end
        DATA: begin
          if (crsdv_in) begin
            axiov   <= 1'b1;
            axiod   <= rxd_in;
            sof_out <= first;
            first   <= 1'b0;
          end else begin
            state   <= IDLE;
            eof_out <= ~first;
            first   <= 1'b0;
          end
        end
        DISCARD: begin
          if (!crsdv_in) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/ether_rx.md
ETHER_RX -- requirements
Module: ether_rx

Interface
REQ-001 SHALL have parameter MIN_PREAMBLE, default 8, meaning the minimum consecutive 2'b01 dibits (preamble plus SFD leader) required before the SFD-terminating 2'b11 is accepted; legal range 1..31.
REQ-002 SHALL have port clk_in  input  1  system clock, 50 MHz, shared with the RMII reference clock.
REQ-003 SHALL have port rst_in  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port crsdv_in  input  1  RMII carrier-sense/data-valid.
REQ-005 SHALL have port rxd_in  input  2  RMII receive dibit, rxd_in[0] first on the wire.
REQ-006 SHALL have port axiov  output  1  payload dibit valid (destination MAC onward, FCS included).
REQ-007 SHALL have port axiod  output  2  payload dibit, same bit order as rxd_in.
REQ-008 SHALL have port sof_out  output  1  one-cycle pulse coincident with the first payload dibit.
REQ-009 SHALL have port eof_out  output  1  one-cycle pulse on the cycle after the last payload dibit.

Function
REQ-010 SHALL sample crsdv_in and rxd_in on every rising clk_in edge; all outputs SHALL be registered.
REQ-011 SHALL implement the states IDLE, PREAMBLE, DATA and DISCARD.
REQ-012 IDLE: crsdv_in=1 and rxd_in=2'b01 -> PREAMBLE with count=1; crsdv_in=1 and any other dibit -> DISCARD; crsdv_in=0 -> stay in IDLE.
REQ-013 PREAMBLE: rxd_in=2'b01 -> count increments, saturating at 31.
REQ-014 PREAMBLE: rxd_in=2'b11 with count>=MIN_PREAMBLE -> DATA.
REQ-015 PREAMBLE: rxd_in=2'b11 with count<MIN_PREAMBLE, or rxd_in=2'b00 or 2'b10 -> DISCARD.
REQ-016 PREAMBLE: crsdv_in=0 -> IDLE, with no output activity.
REQ-017 DATA: each cycle with crsdv_in=1 SHALL produce axiov=1 and axiod=rxd_in one cycle later (latency 1); the first such dibit SHALL also assert sof_out.
REQ-018 DATA: crsdv_in=0 -> IDLE; axiov=0 on the following cycle, with eof_out=1 on that same cycle.
REQ-019 DISCARD: SHALL hold every output at 0 until crsdv_in=0, then -> IDLE.
REQ-020 A frame of zero payload dibits (crsdv_in falls on the cycle after SFD) SHALL produce neither sof_out nor eof_out.
REQ-021 Back-to-back frames SHALL be accepted when crsdv_in is low for at least one cycle between them.
REQ-022 axiov, sof_out and eof_out SHALL be 0 in every state except as stated in REQ-017 and REQ-018.

Reset
REQ-023 rst_in=1 SHALL immediately force state=IDLE, count=0, axiov=0, axiod=2'b00, sof_out=0, eof_out=0 (and err_out=0 when compiled in).
REQ-024 rst_in asserted mid-frame SHALL abort the frame without an eof_out pulse.
REQ-025 After rst_in deasserts, the block SHALL enter DISCARD if crsdv_in is already high, and IDLE otherwise.

Configuration
REQ-026 When the macro ETHER_RX_ERR_EN is defined, the block SHALL add port err_out  output  1, which pulses for one cycle on every PREAMBLE->DISCARD or IDLE->DISCARD transition.
REQ-027 When ETHER_RX_ERR_EN is undefined, err_out SHALL be absent and there SHALL be no logic change elsewhere.

Structure
REQ-028 The state enum and the constants PREAMBLE_DIBIT=2'b01 and SFD_DIBIT=2'b11 SHALL live in shared package ether_pkg.
REQ-029 The design SHALL be a single module with no sub-modules; the count SHALL be 5 bits wide.

Verification
REQ-030 Frame check: reset, then 31x 2'b01, 1x 2'b11, 16 payload dibits of 32'hBF7BBEFB (MSB-first by dibit), then crsdv_in=0 -> exactly 16 axiov cycles with matching axiod, sof_out on the first, eof_out one cycle after the last.
REQ-031 Short preamble (MIN_PREAMBLE=8): 5x 2'b01 then 2'b11 then data -> axiov stays 0 for the whole frame; err_out=1 once when compiled in.
REQ-032 Corrupt preamble: 10x 2'b01, 2'b10, then 20x 2'b01, 2'b11, data, all in one carrier -> no output.
REQ-033 Reset mid-frame: assert rst_in after 6 payload dibits -> outputs 0 immediately, no eof_out; the next valid frame is received intact.
REQ-034 Back-to-back: two valid frames separated by one crsdv_in=0 cycle -> two sof_out/eof_out pairs with the correct dibit counts.
REQ-035 Zero-length frame: preamble and SFD, then immediate crsdv_in=0 -> no sof_out, eof_out or axiov.
